// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// one transaction at a time, returning read data to the port that owns it.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   localparam int unsigned LAT_W = 2;
   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   state_t            r_state;
   owner_t            r_owner;
   logic [LAT_W-1:0]  r_lat;
   logic [CNT_W-1:0]  r_starve;
   logic              r_if_rvalid;
   logic              r_d_rvalid;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic w_idle;
   logic w_starved;
   logic w_if_win;
   logic w_if_take;
   logic w_d_take;

   // Data normally wins; fetch wins once it has watched STARVE_MAX data grants go by.
   assign w_idle    = (r_state == ST_IDLE);
   assign w_starved = (r_starve == CNT_W'(STARVE_MAX));
   assign w_if_win  = if_req && (!d_req || w_starved);
   assign w_if_take = w_idle && w_if_win;
   assign w_d_take  = w_idle && d_req && !w_if_win;

   // Grants are Mealy outputs; held low while reset is asserted.
   assign if_gnt    = rst_n && w_if_take;
   assign d_gnt     = rst_n && w_d_take;

   assign if_rvalid = r_if_rvalid;
   assign if_rdata  = r_if_rdata;
   assign d_rvalid  = r_d_rvalid;
   assign d_rdata   = r_d_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = (r_state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWN_NONE;
         r_lat       <= '0;
         r_starve    <= '0;
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_mem_en    <= 1'b0;

         // Starvation count only grows while fetch is actually waiting.
         if (!if_req || w_if_take) begin
            r_starve <= '0;
         end else if (w_d_take && !w_starved) begin
            r_starve <= r_starve + CNT_W'(1);
         end

         case (r_state)
            ST_IDLE: begin
               if (w_if_take) begin
                  r_mem_addr <= if_addr;
                  r_mem_we   <= 1'b0;
                  r_mem_en   <= 1'b1;
                  r_owner    <= OWN_IF;
                  r_state    <= ST_CMD;
               end else if (w_d_take) begin
                  r_mem_addr  <= d_addr;
                  r_mem_we    <= d_we;
                  r_mem_wdata <= d_wdata;
                  r_mem_en    <= 1'b1;
                  r_owner     <= OWN_D;
                  r_state     <= ST_CMD;
               end
            end
            ST_CMD: begin
               r_lat <= '0;
               if (r_mem_we) begin
                  r_owner <= OWN_NONE;
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_lat == LAT_W'(RD_LAT - 1)) begin
                  if (r_owner == OWN_D) begin
                     r_d_rdata  <= mem_rdata;
                     r_d_rvalid <= 1'b1;
                  end else if (r_owner == OWN_IF) begin
                     r_if_rdata  <= mem_rdata;
                     r_if_rvalid <= 1'b1;
                  end
                  r_lat   <= '0;
                  r_owner <= OWN_NONE;
                  r_state <= ST_IDLE;
               end else begin
                  r_lat <= r_lat + LAT_W'(1);
               end
            end
            default: begin
               r_owner <= OWN_NONE;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
module tb_mem_port_arbiter;
   typedef struct {
      int          inst;
      int          kind;
      logic [15:0] a;
      logic [15:0] d;
      int          cyc;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic        if_req [2];
   logic [15:0] if_addr [2];
   logic        if_gnt [2];
   logic        if_rvalid [2];
   logic [15:0] if_rdata [2];
   logic        d_req [2];
   logic        d_we [2];
   logic [15:0] d_addr [2];
   logic [15:0] d_wdata [2];
   logic        d_gnt [2];
   logic        d_rvalid [2];
   logic [15:0] d_rdata [2];
   logic        mem_en [2];
   logic        mem_we [2];
   logic [15:0] mem_addr [2];
   logic [15:0] mem_wdata [2];
   logic [15:0] mem_rdata [2];
   logic        busy [2];

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   ev_t q_gnt[$];
   ev_t q_mem[$];
   ev_t q_rsp[$];

   logic [15:0] mem [logic [15:0]];
   logic        pv [2][1:3] = '{default: 1'b0};
   logic [15:0] pd [2][1:3] = '{default: 16'h0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
      .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
      .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
   );

   // Memory model: fixed contents for known addresses, written values override them.
   function automatic logic [15:0] rd_mem(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      case (a)
         16'h0010: return 16'hA5A5;
         16'h0300: return 16'h5A3C;
         default:  return a ^ 16'hC3C3;
      endcase
   endfunction

   // Read data appears only in the cycle exactly RD_LAT cycles after the command.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mem_en[i] && mem_we[i]) mem[mem_addr[i]] = mem_wdata[i];
         pv[i][1] <= mem_en[i] && !mem_we[i];
         pd[i][1] <= rd_mem(mem_addr[i]);
         for (int k = 2; k <= 3; k++) begin
            pv[i][k] <= pv[i][k-1];
            pd[i][k] <= pd[i][k-1];
         end
      end
   end
   assign mem_rdata[0] = pv[0][1] ? pd[0][1] : 16'hDEAD;
   assign mem_rdata[1] = pv[1][3] ? pd[1][3] : 16'hDEAD;

   task automatic exp_gnt(input int inst, input int port, input int c);
      ev_t e;
      e.inst = inst; e.kind = port; e.a = 16'h0; e.d = 16'h0; e.cyc = c;
      q_gnt.push_back(e);
   endtask

   task automatic exp_mem(input int inst, input int we, input logic [15:0] a,
                          input logic [15:0] d, input int c);
      ev_t e;
      e.inst = inst; e.kind = we; e.a = a; e.d = d; e.cyc = c;
      q_mem.push_back(e);
   endtask

   task automatic exp_rsp(input int inst, input int port, input logic [15:0] d, input int c);
      ev_t e;
      e.inst = inst; e.kind = port; e.a = 16'h0; e.d = d; e.cyc = c;
      q_rsp.push_back(e);
   endtask

   task automatic match(input int qs, input int inst, input int kind,
                        input logic [15:0] a, input logic [15:0] d);
      ev_t   e;
      bit    have;
      string nm;
      nm   = (qs == 0) ? "gnt" : (qs == 1) ? "mem" : "rsp";
      have = 1'b0;
      case (qs)
         0: if (q_gnt.size() != 0) begin e = q_gnt.pop_front(); have = 1'b1; end
         1: if (q_mem.size() != 0) begin e = q_mem.pop_front(); have = 1'b1; end
         default: if (q_rsp.size() != 0) begin e = q_rsp.pop_front(); have = 1'b1; end
      endcase
      checks++;
      if (!have) begin
         failures++;
         $display("FAIL %s unexpected: got inst=%0d kind=%0d a=%h d=%h cyc=%0d, required none",
                  nm, inst, kind, a, d, cyc);
      end else if (e.inst != inst || e.kind != kind || e.a != a || e.d != d || e.cyc != cyc) begin
         failures++;
         $display("FAIL %s: got inst=%0d kind=%0d a=%h d=%h cyc=%0d, required inst=%0d kind=%0d a=%h d=%h cyc=%0d",
                  nm, inst, kind, a, d, cyc, e.inst, e.kind, e.a, e.d, e.cyc);
      end
   endtask

   // Monitor: every DUT event is matched against the head of its expectation queue.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (if_gnt[i] && d_gnt[i]) begin
            checks++;
            failures++;
            $display("FAIL gnt_both inst=%0d cyc=%0d: got two grants, required one", i, cyc);
         end
         if (if_gnt[i] || d_gnt[i]) match(0, i, d_gnt[i] ? 1 : 0, 16'h0, 16'h0);
         if (mem_en[i]) match(1, i, int'(mem_we[i]), mem_addr[i],
                              mem_we[i] ? mem_wdata[i] : 16'h0);
         if (if_rvalid[i]) match(2, i, 0, 16'h0, if_rdata[i]);
         if (d_rvalid[i])  match(2, i, 1, 16'h0, d_rdata[i]);
      end
   end

   task automatic chk(input string nm, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d cyc=%0d: got %h, required %h", nm, inst, cyc, act, exp);
      end
   endtask

   task automatic chk_zero(input int i);
      chk("z_if_gnt",    i, 32'(if_gnt[i]),    32'h0);
      chk("z_d_gnt",     i, 32'(d_gnt[i]),     32'h0);
      chk("z_if_rvalid", i, 32'(if_rvalid[i]), 32'h0);
      chk("z_d_rvalid",  i, 32'(d_rvalid[i]),  32'h0);
      chk("z_if_rdata",  i, 32'(if_rdata[i]),  32'h0);
      chk("z_d_rdata",   i, 32'(d_rdata[i]),   32'h0);
      chk("z_mem_en",    i, 32'(mem_en[i]),    32'h0);
      chk("z_mem_we",    i, 32'(mem_we[i]),    32'h0);
      chk("z_mem_addr",  i, 32'(mem_addr[i]),  32'h0);
      chk("z_mem_wdata", i, 32'(mem_wdata[i]), 32'h0);
      chk("z_busy",      i, 32'(busy[i]),      32'h0);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Requesters hold req until granted, then release it just after the edge.
   task automatic req_if_t(input int i, input logic [15:0] a);
      bit ok;
      ok = 1'b0;
      if_addr[i] = a;
      if_req[i]  = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         ok = if_gnt[i];
         @(posedge clk);
         #1;
         if (ok) break;
      end
      if_req[i] = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL if_gnt_timeout inst=%0d: got no grant, required a grant", i);
      end
   endtask

   task automatic req_d_t(input int i, input logic we, input logic [15:0] a,
                          input logic [15:0] wd);
      bit ok;
      ok = 1'b0;
      d_we[i]    = we;
      d_addr[i]  = a;
      d_wdata[i] = wd;
      d_req[i]   = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         ok = d_gnt[i];
         @(posedge clk);
         #1;
         if (ok) break;
      end
      d_req[i] = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL d_gnt_timeout inst=%0d: got no grant, required a grant", i);
      end
   endtask

   initial begin
      int t0;
      for (int i = 0; i < 2; i++) begin
         if_req[i] = 1'b0; if_addr[i] = 16'h0;
         d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = 16'h0; d_wdata[i] = 16'h0;
      end
      rst_n = 1'b0;
      step(1);
      // Reset: outputs zero and grants suppressed even with requests present.
      if_req[0] = 1'b1; d_req[0] = 1'b1; d_req[1] = 1'b1;
      #1;
      chk_zero(0);
      chk_zero(1);
      if_req[0] = 1'b0; d_req[0] = 1'b0; d_req[1] = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(2);

      // Fetch read, RD_LAT=1
      t0 = cyc;
      exp_gnt(0, 0, t0);
      exp_mem(0, 0, 16'h0010, 16'h0, t0 + 1);
      exp_rsp(0, 0, 16'hA5A5, t0 + 3);
      req_if_t(0, 16'h0010);
      step(4);

      // Simultaneous requests: data write first, then fetch
      t0 = cyc;
      exp_gnt(0, 1, t0);
      exp_mem(0, 1, 16'h0200, 16'h1234, t0 + 1);
      exp_gnt(0, 0, t0 + 2);
      exp_mem(0, 0, 16'h0010, 16'h0, t0 + 3);
      exp_rsp(0, 0, 16'hA5A5, t0 + 5);
      fork
         req_d_t(0, 1'b1, 16'h0200, 16'h1234);
         req_if_t(0, 16'h0010);
      join
      step(5);

      // Starvation: four data grants, then fetch, then data resumes
      t0 = cyc;
      for (int k = 0; k < 7; k++) begin
         int g;
         g = t0 + 3 * k;
         if (k == 4) begin
            exp_gnt(0, 0, g);
            exp_mem(0, 0, 16'h0010, 16'h0, g + 1);
            exp_rsp(0, 0, 16'hA5A5, g + 3);
         end else begin
            exp_gnt(0, 1, g);
            exp_mem(0, 0, 16'h0200, 16'h0, g + 1);
            exp_rsp(0, 1, 16'h1234, g + 3);
         end
      end
      fork
         begin
            for (int k = 0; k < 6; k++) req_d_t(0, 1'b0, 16'h0200, 16'h0);
         end
         req_if_t(0, 16'h0010);
      join
      step(5);

      // Fetch pulse while busy is ignored
      t0 = cyc;
      exp_gnt(0, 1, t0);
      exp_mem(0, 1, 16'h0400, 16'hBEEF, t0 + 1);
      fork
         req_d_t(0, 1'b1, 16'h0400, 16'hBEEF);
         begin
            step(1);
            if_addr[0] = 16'h0010;
            if_req[0]  = 1'b1;
            @(negedge clk);
            chk("busy_cmd", 0, 32'(busy[0]), 32'h1);
            step(1);
            if_req[0] = 1'b0;
         end
      join
      step(4);

      // Reset during WAIT drops the read
      t0 = cyc;
      exp_gnt(0, 1, t0);
      exp_mem(0, 0, 16'h0300, 16'h0, t0 + 1);
      req_d_t(0, 1'b0, 16'h0300, 16'h0);
      step(1);
      chk("busy_wait", 0, 32'(busy[0]), 32'h1);
      rst_n = 1'b0;
      #1;
      chk_zero(0);
      step(2);
      rst_n = 1'b1;
      step(4);
      chk("busy_after_rst", 0, 32'(busy[0]), 32'h0);
      t0 = cyc;
      exp_gnt(0, 1, t0);
      exp_mem(0, 0, 16'h0400, 16'h0, t0 + 1);
      exp_rsp(0, 1, 16'hBEEF, t0 + 3);
      req_d_t(0, 1'b0, 16'h0400, 16'h0);
      step(4);
      chk("d_rdata_hold", 0, 32'(d_rdata[0]), 32'hBEEF);
      chk("if_rdata_hold", 0, 32'(if_rdata[0]), 32'h0);

      // Data read with RD_LAT=3
      t0 = cyc;
      exp_gnt(1, 1, t0);
      exp_mem(1, 0, 16'h0300, 16'h0, t0 + 1);
      exp_rsp(1, 1, 16'h5A3C, t0 + 5);
      fork
         req_d_t(1, 1'b0, 16'h0300, 16'h0);
         begin
            for (int k = 0; k <= 5; k++) begin
               @(negedge clk);
               chk("busy_lat3", 1, 32'(busy[1]), (k >= 1 && k <= 4) ? 32'h1 : 32'h0);
               @(posedge clk);
            end
         end
      join
      step(3);

      chk("q_gnt_left", 0, 32'(q_gnt.size()), 32'h0);
      chk("q_mem_left", 0, 32'(q_mem.size()), 32'h0);
      chk("q_rsp_left", 0, 32'(q_rsp.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, required completion");
      $fatal(1);
   end

endmodule
